// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_pkg
//  Purpose  : Shared types and constants for the serial frame transmitter and
//             the matching receiver controller.
//  Contents : state_t FSM encoding, field widths, idle line level, and a
//             bit-select helper used to mux a field bit by a counter value.
//  Revision : 1.0  initial release
// ============================================================================
package serial_frame_pkg;

   localparam int   PORT_W     = 2;
   localparam int   LEN_W      = 4;
   localparam int   DATA_W     = 15;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      PORT  = 3'd2,
      LEN   = 3'd3,
      DATA  = 3'd4,
      FIN   = 3'd5
   } state_t;

   // Picks vec[idx]. Going through a shift keeps the index width independent
   // of the field width; fields up to 32 bits are supported.
   function automatic logic sel_bit(input logic [31:0] vec, input logic [4:0] idx);
      logic [31:0] sh;
      sh = vec >> idx;
      return sh[0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_tx_if
//  Purpose  : Request/status bundle of the serial frame transmitter.
//  Signals  : clkEn (bit-advance enable), start, port, len, data (request),
//             SerOut (serial line), busy, Done (status).
//  Modports : master - frame source / observer; slave - the transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_frame_tx_if #(
   parameter int LEN_W  = serial_frame_pkg::LEN_W,
   parameter int DATA_W = serial_frame_pkg::DATA_W
);
   logic                                clkEn;
   logic                                start;
   logic [serial_frame_pkg::PORT_W-1:0] port;
   logic [LEN_W-1:0]                    len;
   logic [DATA_W-1:0]                   data;
   logic                                SerOut;
   logic                                busy;
   logic                                Done;

   modport master (
      output clkEn, start, port, len, data,
      input  SerOut, busy, Done
   );

   modport slave (
      input  clkEn, start, port, len, data,
      output SerOut, busy, Done
   );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx_bit_down_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_down_counter
//  Purpose  : Loadable down-counter that walks the bit index of the field
//             currently being sent.
//  Ports    : clk, rst (sync, active high); ld/ld_val load; en decrements;
//             cnt current value; co high when cnt is zero.
//  Revision : 1.0  initial release
// ============================================================================
module bit_down_counter #(
   parameter int W = 4
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         ld,
   input  wire logic [W-1:0] ld_val,
   input  wire logic         en,
   output logic      [W-1:0] cnt,
   output logic              co
);
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (ld)
         cnt <= ld_val;
      else if (en)
         cnt <= cnt - W'(1);
   end

   assign co = (cnt == '0);
endmodule
`default_nettype wire

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_tx
//  Purpose  : Sends start bit, 2-bit port, LEN_W-bit length (MSB first) and
//             len payload bits (MSB first), one bit per clkEn cycle.
//  Ports    : clk, rst (sync, active high); bus (serial_frame_tx_if.slave):
//             clkEn, start, port, len, data in; SerOut, busy, Done out.
//  Revision : 1.0  initial release
// ============================================================================
module serial_frame_tx #(
   parameter int LEN_W  = serial_frame_pkg::LEN_W,
   parameter int DATA_W = serial_frame_pkg::DATA_W
) (
   input wire logic          clk,
   input wire logic          rst,
   serial_frame_tx_if.slave  bus
);
   import serial_frame_pkg::*;

   state_t              state, state_nxt;
   logic [PORT_W-1:0]   port_q;
   logic [LEN_W-1:0]    len_q;
   logic [DATA_W-1:0]   data_q;
   logic                ser_q, ser_nxt;
   logic                busy_q, busy_nxt;
   logic                done_q, done_nxt;
   logic                capture;
   logic                cnt_ld, cnt_en, cnt_co;
   logic [LEN_W-1:0]    cnt_ld_val, cnt, cnt_m1, len_m1;

   bit_down_counter #(.W(LEN_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (cnt_ld),
      .ld_val (cnt_ld_val),
      .en     (cnt_en),
      .cnt    (cnt),
      .co     (cnt_co)
   );

   assign cnt_m1 = cnt - LEN_W'(1);
   assign len_m1 = len_q - LEN_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         port_q <= '0;
         len_q  <= '0;
         data_q <= '0;
         ser_q  <= IDLE_LEVEL;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         ser_q  <= ser_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         if (capture) begin
            port_q <= bus.port;
            len_q  <= bus.len;
            data_q <= bus.data;
         end
      end
   end

   // The line is registered, so every transition also selects the bit that
   // the next state will present; without clkEn the line simply holds.
   always_comb begin
      state_nxt  = state;
      ser_nxt    = ser_q;
      capture    = 1'b0;
      cnt_ld     = 1'b0;
      cnt_ld_val = '0;
      cnt_en     = 1'b0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            ser_nxt = IDLE_LEVEL;
            if (bus.start) begin
               capture   = 1'b1;
               state_nxt = START;
               ser_nxt   = 1'b0;
            end
         end
         START: if (bus.clkEn) begin
            state_nxt  = PORT;
            cnt_ld     = 1'b1;
            cnt_ld_val = LEN_W'(1);
            ser_nxt    = port_q[1];
         end
         PORT: if (bus.clkEn) begin
            if (cnt_co) begin
               state_nxt  = LEN;
               cnt_ld     = 1'b1;
               cnt_ld_val = LEN_W'(LEN_W - 1);
               ser_nxt    = len_q[LEN_W-1];
            end else begin
               // PORT only ever sees cnt = 1 and 0, so the bit after 1 is 0.
               cnt_en  = 1'b1;
               ser_nxt = port_q[0];
            end
         end
         LEN: if (bus.clkEn) begin
            if (cnt_co) begin
               if (len_q != '0) begin
                  state_nxt  = DATA;
                  cnt_ld     = 1'b1;
                  cnt_ld_val = len_m1;
                  ser_nxt    = sel_bit(32'(data_q), 5'(len_m1));
               end else begin
                  state_nxt = FIN;
                  ser_nxt   = IDLE_LEVEL;
               end
            end else begin
               cnt_en  = 1'b1;
               ser_nxt = sel_bit(32'(len_q), 5'(cnt_m1));
            end
         end
         DATA: if (bus.clkEn) begin
            if (cnt_co) begin
               state_nxt = FIN;
               ser_nxt   = IDLE_LEVEL;
            end else begin
               cnt_en  = 1'b1;
               ser_nxt = sel_bit(32'(data_q), 5'(cnt_m1));
            end
         end
         FIN: begin
            state_nxt = IDLE;
            ser_nxt   = IDLE_LEVEL;
         end
         default: begin
            state_nxt = IDLE;
            ser_nxt   = IDLE_LEVEL;
         end
      endcase
      busy_nxt = (state_nxt == START) || (state_nxt == PORT) ||
                 (state_nxt == LEN)   || (state_nxt == DATA);
      done_nxt = (state_nxt == FIN);
   end

   assign bus.SerOut = ser_q;
   assign bus.busy   = busy_q;
   assign bus.Done   = done_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_frame_tx
//  Purpose  : Drives serial_frame_tx with directed and random requests and
//             compares SerOut/busy/Done every cycle against a frame-queue
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_frame_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_frame_tx_if bus ();

   serial_frame_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model: the whole frame is expanded into a bit queue on
   // acceptance; the queue head is the bit on the line.
   bit mq[$];
   int m_mode   = 0;          // 0 idle, 1 sending, 2 end-of-frame cycle
   bit exp_ser  = 1'b1;
   bit exp_busy = 1'b0;
   bit exp_done = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit ce,
                             input bit [1:0] p, input bit [3:0] l, input bit [14:0] d);
      if (r) begin
         m_mode = 0;
         mq.delete();
         exp_ser = 1; exp_busy = 0; exp_done = 0;
      end else begin
         case (m_mode)
            0: begin
               if (s) begin
                  mq.delete();
                  mq.push_back(1'b0);
                  mq.push_back(p[1]);
                  mq.push_back(p[0]);
                  for (int i = 3; i >= 0; i--) mq.push_back(l[i]);
                  for (int i = int'(l) - 1; i >= 0; i--) mq.push_back(d[i]);
                  m_mode = 1;
                  exp_ser = mq[0]; exp_busy = 1; exp_done = 0;
               end else begin
                  exp_ser = 1; exp_busy = 0; exp_done = 0;
               end
            end
            1: begin
               if (ce) begin
                  void'(mq.pop_front());
                  if (mq.size() == 0) begin
                     m_mode = 2;
                     exp_ser = 1; exp_busy = 0; exp_done = 1;
                  end else begin
                     exp_ser = mq[0];
                  end
               end
            end
            default: begin
               m_mode = 0;
               exp_ser = 1; exp_busy = 0; exp_done = 0;
            end
         endcase
      end
   endtask

   // One clock: apply inputs at the falling edge, predict, then check the
   // outputs at the next falling edge.
   task automatic cycle(input bit r, input bit s, input bit ce,
                        input bit [1:0] p, input bit [3:0] l, input bit [14:0] d);
      rst       = r;
      bus.start = s;
      bus.clkEn = ce;
      bus.port  = p;
      bus.len   = l;
      bus.data  = d;
      model_step(r, s, ce, p, l, d);
      @(posedge clk);
      @(negedge clk);
      check_val("SerOut", {31'd0, bus.SerOut}, {31'd0, exp_ser});
      check_val("busy",   {31'd0, bus.busy},   {31'd0, exp_busy});
      check_val("Done",   {31'd0, bus.Done},   {31'd0, exp_done});
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 1, 2'b00, 4'd0, 15'd0);
   endtask

   int dens;

   initial begin
      bus.start = 0; bus.clkEn = 0; bus.port = 0; bus.len = 0; bus.data = 0;
      @(negedge clk);

      // Reset state.
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 2'b00, 4'd0, 15'd0);
      idle_cycles(2);

      // port 2, len 3, data 101, clkEn tied high.
      cycle(0, 1, 1, 2'b10, 4'd3, 15'b101);
      idle_cycles(14);

      // len 0: no payload.
      cycle(0, 1, 1, 2'b01, 4'd0, 15'h7fff);
      idle_cycles(10);

      // clkEn every 4th cycle, maximum length, alternating payload.
      for (int k = 0; k < 4 * 24 + 8; k++)
         cycle(0, (k == 1), (k % 4 == 0), 2'b11, 4'd15, 15'h5555);
      idle_cycles(3);

      // start held high, inputs churning while busy.
      for (int k = 0; k < 2 * (6 + 9) + 4; k++)
         cycle(0, 1, 1, 2'($urandom), 4'd6, 15'($urandom));
      idle_cycles(4);

      // Reset in the middle of the payload, then a clean frame.
      cycle(0, 1, 1, 2'b11, 4'd12, 15'h6b3d);
      idle_cycles(10);
      cycle(1, 0, 1, 2'b00, 4'd0, 15'd0);
      idle_cycles(25);
      cycle(0, 1, 1, 2'b10, 4'd12, 15'h1a5c);
      idle_cycles(24);

      // Random traffic with varying clkEn density and rare resets.
      dens = 0;
      for (int k = 0; k < 1200; k++) begin
         if (k % 150 == 0) dens = $urandom_range(0, 3);
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, dens) == 0),
               2'($urandom), 4'($urandom), 15'($urandom));
      end
      idle_cycles(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that produces the bit stream the serial-port demultiplexer consumes: a start bit, a 2-bit destination port, a 4-bit payload length and then the payload bits. It serves as the stimulus source for the receiver on the board, and as a loop-back partner for it. It advances one bit per `clkEn` cycle, so it can share the one-pulser enable with the receiver.

## Interface
Parameters:
- `LEN_W`, 4: width of the length field; the maximum payload is 2^LEN_W−1 bits.
- `DATA_W`, 15: payload register width; must be ≥ 2^LEN_W−1.

Ports:
- `clk`  in  1  single system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clkEn`  in  1  bit-advance enable (one-pulser output or tied high).
- `start`  in  1  request to send a frame; level-sampled in IDLE only.
- `port`  in  2  destination port number.
- `len`  in  LEN_W  payload length in bits; 0 is legal.
- `data`  in  DATA_W  payload; bits `data[len-1:0]` are sent.
- `SerOut`  out  1  serial line, registered; idle level 1.
- `busy`  out  1  high from frame acceptance until Done is asserted.
- `Done`  out  1  one-`clk` pulse marking the end of the frame.

## Operation
- Frame on `SerOut`: start bit `0`, then `port[1]`, `port[0]`, then `len` MSB first, then `data[len-1]` down to `data[0]`. The line returns to `1` after the frame.
- The FSM has the states IDLE, START, PORT, LEN, DATA and FIN.
- IDLE: `SerOut`=1, `busy`=0.
  - `start`=1 captures `port`, `len` and `data` into internal registers in that cycle, independent of `clkEn`.
  - The next state is START.
- START: `SerOut`=0. On `clkEn` the FSM goes to PORT and the bit counter loads 1.
- PORT: drives `port` bit[cnt]. On `clkEn` it decrements; after bit 0 it goes to LEN with the counter at LEN_W−1.
- LEN: drives `len` bit[cnt]. After bit 0, on `clkEn`:
  - it goes to DATA with the counter at `len`−1 if `len`≠0;
  - otherwise it goes straight to FIN.
- DATA: drives `data[cnt]`. After `cnt`=0, on `clkEn` it goes to FIN.
- FIN: `SerOut`=1, `Done`=1 and `busy`=0 for exactly one `clk`, independent of `clkEn`. The next state is IDLE.
- `start` is ignored in every state other than IDLE, including FIN. Input changes while busy have no effect because the captured copies are used.
- `len`=0 gives a 7-bit frame with no payload.
- Reset has priority over all other activity, including in mid-frame. After reset:
  - state IDLE;
  - `SerOut`=1, `busy`=0, `Done`=0;
  - counter and capture registers cleared.
- A frame cut off by reset is not resumed.

## Timing
- All outputs are registered. Let the acceptance cycle be n, meaning `start` is sampled high in IDLE.
  - At n+1: `SerOut`=0 and `busy`=1.
- Each bit holds until the first `clk` edge with `clkEn`=1 after the bit appears, and changes on the following edge.
- With `clkEn` tied high, the schedule is:
  - start bit at n+1;
  - port bits at n+2 and n+3;
  - length bits at n+4 to n+7;
  - payload at n+8 to n+7+`len`;
  - `Done` at n+8+`len`.
- Earliest next acceptance is n+9+`len`, when the FSM is back in IDLE. This gives a back-to-back frame period of `len`+9 cycles.
- With a sparse `clkEn`, every bit lasts until the next `clkEn` cycle, whatever the spacing. FIN and the IDLE acceptance never wait for `clkEn`.

## Structure
- Package `serial_frame_pkg`:
  - state enum (IDLE, START, PORT, LEN, DATA, FIN);
  - `PORT_W`=2, `LEN_W`, `DATA_W`;
  - the constant `IDLE_LEVEL`=1.
  - The receiver's controller imports the same package.
- Sub-module `bit_down_counter`: loadable LEN_W-bit down-counter with `ld`, `en` and a zero flag (`co`). The FSM uses it for the PORT, LEN and DATA fields.
- Bit selection is a mux indexed by the counter, not a shift register, so the captured fields stay observable for debug.

## Test plan
- `clkEn`=1, `port`=2'b10, `len`=3, `data`=15'b101, `start` pulsed at cycle 0:
  - `SerOut` from cycle 1 is 0,1,0,0,0,1,1,1,0,1 then 1;
  - `Done`=1 at cycle 11 only; `busy` is high over cycles 1–10.
- `len`=0, `port`=2'b01:
  - `SerOut` is 0,0,1,0,0,0,0 over cycles 1–7;
  - `Done` at cycle 8, with no payload bits.
- `clkEn` pulsed every 4 cycles, `len`=15, `data`=15'h5555:
  - each bit is held for exactly 4 cycles;
  - the payload alternates 1,0,…,1;
  - `Done` follows the last bit by one `clkEn` edge.
- `start` held high continuously and `data` changed mid-frame:
  - the second frame begins exactly `len`+9 cycles after the first acceptance;
  - the first frame's payload is unchanged.
- `rst` asserted during the DATA state:
  - the next cycle shows `SerOut`=1, `busy`=0, `Done`=0;
  - no `Done` pulse;
  - a new `start` then produces a full, clean frame.
- Loop-back: connect `SerOut` to the receiver's `SerIn` and share `clkEn`. For each port 0–3 with `len`=5 and `data`=5'b10011:
  - the receiver's matching port output shows 1,0,0,1,1;
  - the receiver's `Done` is asserted.
